rng_lfsr_range: RTL and testbench

Parametrised LFSR random number generator; the successor to the fixed 8-bit `rng` block. Adds configurable width and tap polynomial, runtime seed load, and a request/valid handshake. Optionally returns values bounded to `[0, limit]` by rejection sampling, with a bounded retry count. Sits between the board switch/keys and the display/game logic that consumes random values.

---
 rtl/rng_lfsr_range.sv | 126 ++++++++++++
 tb/tb_rng_lfsr_range.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rng_lfsr_range.sv
// Fibonacci LFSR random source with seed load and req/valid handshake.
// Define RNG_RANGE_EN to add rejection sampling against `limit` with a bounded retry fallback.
module rng_lfsr_range #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
    parameter int               MAX_TRIES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             switch,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             req,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             busy,
    output logic             fallback
);
    // The all-zero state would lock the LFSR, so any zero load becomes 1.
    localparam logic [WIDTH-1:0] RST_VAL = (SEED == '0) ? WIDTH'(1) : SEED;

    typedef enum logic {IDLE, DRAW} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] seed_safe;

    assign lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    assign seed_safe = (seed == '0) ? WIDTH'(1) : seed;

`ifdef RNG_RANGE_EN
    localparam int TW = $clog2(MAX_TRIES + 1);
    logic [TW-1:0] tries_q, tries_d;
    logic          fb_q, fb_d;
`else
    logic unused_limit;
    assign unused_limit = ^limit;
`endif

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        out_d   = out_q;
        valid_d = 1'b0;
`ifdef RNG_RANGE_EN
        tries_d = tries_q;
        fb_d    = fb_q;
`endif
        if (seed_load) begin
            lfsr_d  = seed_safe;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (switch) lfsr_d = lfsr_next;
                    if (req) begin
                        state_d = DRAW;
`ifdef RNG_RANGE_EN
                        tries_d = '0;
`endif
                    end
                end
                DRAW: begin
                    lfsr_d = lfsr_next;
`ifdef RNG_RANGE_EN
                    // An in-range candidate always wins; masking only rescues an exhausted draw.
                    if (lfsr_q <= limit) begin
                        out_d   = lfsr_q;
                        fb_d    = 1'b0;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else if (tries_q == TW'(MAX_TRIES)) begin
                        out_d   = lfsr_q & limit;
                        fb_d    = 1'b1;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tries_d = tries_q + TW'(1);
                    end
`else
                    out_d   = lfsr_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= RST_VAL;
            out_q   <= '0;
            valid_q <= 1'b0;
`ifdef RNG_RANGE_EN
            tries_q <= '0;
            fb_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            out_q   <= out_d;
            valid_q <= valid_d;
`ifdef RNG_RANGE_EN
            tries_q <= tries_d;
            fb_q    <= fb_d;
`endif
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = (state_q == DRAW);
`ifdef RNG_RANGE_EN
    assign fallback = fb_q;
`else
    assign fallback = 1'b0;
`endif
endmodule

// File: tb/tb_rng_lfsr_range.sv
// Randomized bench for rng_lfsr_range against a transaction-level draw model.
module tb_rng_lfsr_range;
    localparam int MT = 2;
`ifdef RNG_RANGE_EN
    localparam bit RANGE = 1'b1;
`else
    localparam bit RANGE = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1, sw = 1'b0, seed_load = 1'b0, req = 1'b0;
    logic [7:0] seed = '0, limit = 8'hFF;
    logic [7:0] out;
    logic       valid, busy, fallback;

    int checks = 0, errors = 0;

    logic [7:0] m_lfsr = 8'h01;
    logic [7:0] m_out  = 8'h00;
    logic       m_fb   = 1'b0;

    rng_lfsr_range #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .MAX_TRIES(MT)) dut (
        .clk(clk), .rst(rst), .switch(sw), .seed_load(seed_load), .seed(seed),
        .req(req), .limit(limit), .out(out), .valid(valid), .busy(busy), .fallback(fallback)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] step(input logic [7:0] v);
        int ones = 0;
        logic [7:0] taps = 8'hB8;
        for (int b = 0; b < 8; b++) if (v[b] && taps[b]) ones++;
        return {v[6:0], 1'(ones % 2)};
    endfunction

    // Each task starts and ends 1 time unit after a rising edge.
    task automatic idle(input int k, input logic s);
        sw = s;
        repeat (k) begin
            @(posedge clk); #1;
            if (s) m_lfsr = step(m_lfsr);
        end
        chk("idle_valid", valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_out", out, m_out);
    endtask

    task automatic draw(input logic [7:0] lim, input bit hold);
        logic [7:0] c;
        int n = 0, edges = 0;
        c = sw ? step(m_lfsr) : m_lfsr;
        forever begin
            if (!RANGE || c <= lim) begin m_out = c; m_fb = 1'b0; break; end
            if (n == MT) begin m_out = c & lim; m_fb = 1'b1; break; end
            n++;
            c = step(c);
        end
        m_lfsr = step(c);
        limit = lim; req = 1'b1;
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        chk("draw_busy", busy, 1);
        while (!valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        req = 1'b0;
        chk("draw_latency", edges, n + 1);
        chk("draw_out", out, m_out);
        chk("draw_fb", fallback, m_fb);
    endtask

    task automatic load(input logic [7:0] s, input logic with_req);
        seed_load = 1'b1; seed = s; req = with_req;
        @(posedge clk); #1;
        seed_load = 1'b0; req = 1'b0;
        m_lfsr = (s == 8'h00) ? 8'h01 : s;
        chk("load_busy", busy, 0);
        chk("load_valid", valid, 0);
    endtask

    task automatic abort_draw(input logic [7:0] s);
        sw = 1'b0; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        chk("abort_busy_pre", busy, 1);
        seed_load = 1'b1; seed = s;
        @(posedge clk); #1;
        seed_load = 1'b0;
        m_lfsr = (s == 8'h00) ? 8'h01 : s;
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        idle(3, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        chk({tag, "_out"}, out, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fb"}, fallback, 0);
        #2 rst = 1'b1;
        sw = 1'b0; req = 1'b0; seed_load = 1'b0;
        m_lfsr = 8'h01; m_out = 8'h00; m_fb = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [7:0] seq [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst_out", out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fb", fallback, 0);
        #4 rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            draw(8'hFF, 1'b0);
            chk("seq_out", out, seq[i]);
        end

`ifdef RNG_RANGE_EN
        load(8'h47, 1'b0);
        draw(8'h20, 1'b0);
        chk("range_accept", out, 8'h1C);
        draw(8'hFF, 1'b0);
        chk("range_next", out, 8'h38);
        load(8'h47, 1'b0);
        draw(8'h0F, 1'b0);
        chk("range_fb_out", out, 8'h0C);
        chk("range_fb_flag", fallback, 1);
`endif

        load(8'h00, 1'b1);
        idle(3, 1'b1);
        sw = 1'b0;
        draw(8'hFF, 1'b0);
        chk("zero_seed_run", out, 8'h08);

        // Reset while valid is high, then mid-draw.
        draw(8'hFF, 1'b1);
        chk("pre_rst_valid", valid, 1);
        do_reset("rst_valid");
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        chk("mid_busy", busy, 1);
        do_reset("rst_draw");
        draw(8'hFF, 1'b0);
        chk("post_rst_out", out, 8'h01);

        abort_draw(8'h5A);
        draw(8'hFF, 1'b0);

        for (int it = 0; it < 80; it++) begin
            logic [7:0] lim;
            lim = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
            case ($urandom_range(0, 5))
                0: idle($urandom_range(1, 5), 1'($urandom));
                1, 2: begin sw = 1'($urandom); draw(lim, 1'($urandom)); end
                3: load(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), 1'($urandom));
                4: abort_draw(8'($urandom));
                default: begin sw = 1'b0; draw(lim, 1'b0); draw(8'($urandom), 1'b1); end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
